// File: rtl/sys_array_tile_scheduler.sv
// Tile scheduler: walks an MxK by KxN product in array-sized tiles, K-slices
// innermost, issuing one descriptor at a time and waiting for its completion.
module sys_array_tile_scheduler #(
  parameter int ARRAY_MAX_W   = 10,
  parameter int ARRAY_MAX_L   = 10,
  parameter int ARRAY_MAX_A_L = 10,
  parameter int DIM_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_WIDTH-1:0] mat_w_w,
  input  logic [DIM_WIDTH-1:0] mat_w_l,
  input  logic [DIM_WIDTH-1:0] mat_a_w,
  input  logic [DIM_WIDTH-1:0] mat_a_l,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [DIM_WIDTH-1:0] tile_row0,
  output logic [DIM_WIDTH-1:0] tile_rows,
  output logic [DIM_WIDTH-1:0] tile_k0,
  output logic [DIM_WIDTH-1:0] tile_k_len,
  output logic [DIM_WIDTH-1:0] tile_col0,
  output logic [DIM_WIDTH-1:0] tile_cols,
  output logic                 tile_accumulate,
  output logic                 tile_last,
  input  logic                 tile_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DIM_WIDTH-1:0] tile_count,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [DIM_WIDTH-1:0] MAX_W   = DIM_WIDTH'(ARRAY_MAX_W);
  localparam logic [DIM_WIDTH-1:0] MAX_L   = DIM_WIDTH'(ARRAY_MAX_L);
  localparam logic [DIM_WIDTH-1:0] MAX_A_L = DIM_WIDTH'(ARRAY_MAX_A_L);

  logic [2:0]           state;
  logic [DIM_WIDTH-1:0] dim_m, dim_k, dim_ka, dim_n;
  logic [DIM_WIDTH-1:0] row0, k0, col0;
  logic                 err_q;
  logic [DIM_WIDTH-1:0] count_q;

  // One extra bit on the block-end sums so offsets near the top of the
  // counter range cannot wrap and fake a "past the end" result.
  logic [DIM_WIDTH:0]   k_end, col_end, row_end;
  logic                 k_wrap, col_wrap, row_wrap, is_last;
  logic [DIM_WIDTH-1:0] rem_rows, rem_k, rem_cols;

  assign k_end    = {1'b0, k0}   + {1'b0, MAX_L};
  assign col_end  = {1'b0, col0} + {1'b0, MAX_A_L};
  assign row_end  = {1'b0, row0} + {1'b0, MAX_W};
  assign k_wrap   = k_end   >= {1'b0, dim_k};
  assign col_wrap = col_end >= {1'b0, dim_n};
  assign row_wrap = row_end >= {1'b0, dim_m};
  assign is_last  = k_wrap && col_wrap && row_wrap;

  assign rem_rows = dim_m - row0;
  assign rem_k    = dim_k - k0;
  assign rem_cols = dim_n - col0;

  // Handshake: a descriptor transfers on any cycle with tile_valid && tile_ready;
  // tile_valid never drops and no field changes until that transfer happens.
  // Descriptor fields read zero whenever tile_valid is low.
  assign tile_valid      = (state == S_ISSUE);
  assign tile_row0       = tile_valid ? row0 : '0;
  assign tile_k0         = tile_valid ? k0   : '0;
  assign tile_col0       = tile_valid ? col0 : '0;
  assign tile_rows       = !tile_valid ? '0 : (rem_rows > MAX_W)   ? MAX_W   : rem_rows;
  assign tile_k_len      = !tile_valid ? '0 : (rem_k    > MAX_L)   ? MAX_L   : rem_k;
  assign tile_cols       = !tile_valid ? '0 : (rem_cols > MAX_A_L) ? MAX_A_L : rem_cols;
  assign tile_accumulate = tile_valid && (k0 != '0);
  assign tile_last       = tile_valid && is_last;

  assign busy       = (state == S_CHECK) || (state == S_ISSUE) || (state == S_WAIT);
  assign done       = (state == S_FINISH);
  assign err        = err_q;
  assign tile_count = count_q;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      dim_m   <= '0;
      dim_k   <= '0;
      dim_ka  <= '0;
      dim_n   <= '0;
      row0    <= '0;
      k0      <= '0;
      col0    <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            dim_m   <= mat_w_w;
            dim_k   <= mat_w_l;
            dim_ka  <= mat_a_w;
            dim_n   <= mat_a_l;
            row0    <= '0;
            k0      <= '0;
            col0    <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((dim_m == '0) || (dim_k == '0) || (dim_ka == '0) || (dim_n == '0) ||
              (dim_k != dim_ka)) begin
            err_q <= 1'b1;
            state <= S_FINISH;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tile_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (tile_done) begin
            count_q <= count_q + DIM_WIDTH'(1);
            if (is_last) begin
              state <= S_FINISH;
            end else begin
              state <= S_ISSUE;
              // K innermost, then columns, then rows.
              if (!k_wrap) begin
                k0 <= k_end[DIM_WIDTH-1:0];
              end else begin
                k0 <= '0;
                if (!col_wrap) begin
                  col0 <= col_end[DIM_WIDTH-1:0];
                end else begin
                  col0 <= '0;
                  row0 <= row_end[DIM_WIDTH-1:0];
                end
              end
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_array_tile_scheduler.sv
// Directed + randomized bench for sys_array_tile_scheduler; expected tiles
// come from a nested-loop model of the tiling order.
module tb_sys_array_tile_scheduler;

  localparam int DW     = 16;
  localparam int MW     = 10;
  localparam int ML     = 10;
  localparam int MAL    = 10;
  localparam int DESC_W = 6 * DW + 2;

  // clock/reset and stimulus signals
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tile_ready = 1'b0;
  logic          tile_done = 1'b0;
  logic [DW-1:0] mat_w_w = '0, mat_w_l = '0, mat_a_w = '0, mat_a_l = '0;

  logic          tile_valid, tile_accumulate, tile_last, busy, done, err;
  logic [DW-1:0] tile_row0, tile_rows, tile_k0, tile_k_len, tile_col0, tile_cols;
  logic [DW-1:0] tile_count;
  logic [2:0]    state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DESC_W-1:0] exp_q[$];
  logic [DESC_W-1:0] desc;

  always #5 clk = ~clk;

  sys_array_tile_scheduler #(
    .ARRAY_MAX_W(MW), .ARRAY_MAX_L(ML), .ARRAY_MAX_A_L(MAL), .DIM_WIDTH(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .mat_w_w(mat_w_w), .mat_w_l(mat_w_l), .mat_a_w(mat_a_w), .mat_a_l(mat_a_l),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_row0(tile_row0), .tile_rows(tile_rows), .tile_k0(tile_k0),
    .tile_k_len(tile_k_len), .tile_col0(tile_col0), .tile_cols(tile_cols),
    .tile_accumulate(tile_accumulate), .tile_last(tile_last),
    .tile_done(tile_done), .busy(busy), .done(done), .err(err),
    .tile_count(tile_count), .state_dbg(state_dbg)
  );

  assign desc = {tile_row0, tile_rows, tile_k0, tile_k_len, tile_col0, tile_cols,
                 tile_accumulate, tile_last};

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, tile_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // reference model: tile list for an MxK * KxN product, K innermost
  task automatic build_model(input int m, input int k, input int n);
    logic [DESC_W-1:0] d;
    exp_q.delete();
    for (int r = 0; r < m; r += MW)
      for (int c = 0; c < n; c += MAL)
        for (int kk = 0; kk < k; kk += ML) begin
          d = {DW'(r), DW'(min_i(m - r, MW)), DW'(kk), DW'(min_i(k - kk, ML)),
               DW'(c), DW'(min_i(n - c, MAL)), (kk != 0), 1'b0};
          exp_q.push_back(d);
        end
    d = exp_q[exp_q.size() - 1];
    d[0] = 1'b1;
    exp_q[exp_q.size() - 1] = d;
  endtask

  task automatic run_job(input int m, input int k, input int aw, input int n,
                         input int first_hold, input int done_dly,
                         input int abort_tile, input bit rnd);
    int tiles;
    int hold;
    int d;
    int total;
    bit bad;
    logic [DESC_W-1:0] e;
    bad = (m == 0) || (k == 0) || (n == 0) || (aw != k);
    exp_q.delete();
    total = 0;
    if (!bad) begin
      build_model(m, k, n);
      total = ((m + MW - 1) / MW) * ((n + MAL - 1) / MAL) * ((k + ML - 1) / ML);
    end
    mat_w_w = DW'(m); mat_w_l = DW'(k); mat_a_w = DW'(aw); mat_a_l = DW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    // dims must have been captured on the start cycle only
    mat_w_w = DW'($urandom); mat_w_l = DW'($urandom);
    mat_a_w = DW'($urandom); mat_a_l = DW'($urandom);
    chk("check_busy", busy, 1'b1);
    chk("check_valid", tile_valid, 1'b0);
    if (bad) begin
      step();
      chk("err_done", done, 1'b1);
      chk("err_flag", err, 1'b1);
      chk("err_busy", busy, 1'b0);
      chk("err_valid", tile_valid, 1'b0);
      step();
      chk("err_done_clear", done, 1'b0);
      chk("err_held", err, 1'b1);
      chk("err_busy_after", busy, 1'b0);
      return;
    end
    step();
    tiles = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("issue_valid", tile_valid, 1'b1);
      chk("desc", desc, e);
      hold = (tiles == 0) ? first_hold : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int h = 0; h < hold; h++) begin
        tile_ready = 1'b0;
        tile_done = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        chk("hold_valid", tile_valid, 1'b1);
        chk("hold_desc", desc, e);
      end
      tile_ready = 1'b1;
      tile_done = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      tile_ready = 1'b0;
      tile_done = 1'b0;
      chk("accept_drop", tile_valid, 1'b0);
      chk("accept_count", tile_count, DW'(tiles));
      d = rnd ? int'($urandom_range(0, 4)) : done_dly;
      for (int i = 0; i < d; i++) begin
        if (rnd && i == 0) start = 1'b1;
        step();
        start = 1'b0;
        chk("wait_valid", tile_valid, 1'b0);
        chk("wait_busy", busy, 1'b1);
      end
      if (tiles == abort_tile) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_quiet("abort");
        chk("abort_count", tile_count, DW'(tiles));
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        chk_quiet("abort_late_done");
        chk("abort_count_frozen", tile_count, DW'(tiles));
        exp_q.delete();
        return;
      end
      tile_done = 1'b1;
      step();
      tile_done = 1'b0;
      tiles++;
      chk("tile_count", tile_count, DW'(tiles));
      if (exp_q.size() == 0) begin
        chk("job_done", done, 1'b1);
        chk("job_done_busy", busy, 1'b0);
        chk("job_done_valid", tile_valid, 1'b0);
        step();
        chk("job_done_clear", done, 1'b0);
        chk("job_idle_busy", busy, 1'b0);
      end
    end
    chk("job_total", tile_count, DW'(total));
    chk("job_err", err, 1'b0);
  endtask

  initial begin
    // reset block
    repeat (3) step();
    chk_quiet("reset");
    chk("reset_desc", desc, '0);
    chk("reset_err", err, 1'b0);
    chk("reset_count", tile_count, '0);
    reset_n = 1'b1;
    step();
    chk_quiet("post_reset");
    chk("post_reset_desc", desc, '0);

    // single tile, done 3 cycles after accept
    run_job(2, 5, 5, 2, 0, 3, -1, 1'b0);
    // six tiles over rows and K
    run_job(25, 12, 12, 10, 0, 1, -1, 1'b0);
    // K mismatch and a zero dim
    run_job(3, 5, 4, 3, 0, 0, -1, 1'b0);
    run_job(0, 5, 5, 3, 0, 0, -1, 1'b0);
    // back-pressure for 7 cycles on the first tile
    run_job(25, 12, 12, 10, 7, 2, -1, 1'b0);
    // abort in WAIT of tile 3, then a full job
    run_job(25, 12, 12, 10, 0, 2, 2, 1'b0);
    run_job(25, 12, 12, 10, 0, 0, -1, 1'b0);

    // start and abort together in IDLE: abort wins
    mat_w_w = 16'd4; mat_w_l = 16'd4; mat_a_w = 16'd4; mat_a_l = 16'd4;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_quiet("start_abort");
    step();
    chk_quiet("start_abort_later");

    // reset while a descriptor is offered
    mat_w_w = 16'd25; mat_w_l = 16'd12; mat_a_w = 16'd12; mat_a_l = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pre_reset_valid", tile_valid, 1'b1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_quiet("mid_reset");
    chk("mid_reset_desc", desc, '0);
    chk("mid_reset_count", tile_count, '0);
    chk("mid_reset_err", err, 1'b0);
    tile_done = 1'b1;
    step();
    tile_done = 1'b0;
    chk_quiet("mid_reset_late_done");
    chk("mid_reset_late_count", tile_count, '0);

    // boundary and randomized jobs
    run_job(10, 10, 10, 10, 0, 0, -1, 1'b1);
    run_job(1, 1, 1, 1, 1, 0, -1, 1'b1);
    run_job(11, 21, 21, 20, 0, 0, -1, 1'b1);
    for (int j = 0; j < 6; j++) begin
      int m, k, n;
      m = int'($urandom_range(1, 35));
      k = int'($urandom_range(1, 35));
      n = int'($urandom_range(1, 35));
      run_job(m, k, k, n, int'($urandom_range(0, 3)), 0, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
